// File: rtl/mul_div_iter.sv
// Iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes on capture, the core iterates unsigned
// (radix-2 shift-add or restoring shift-subtract, one bit per cycle), and the
// sign fix-up is folded into the write of the result register on the last step.
module mul_div_iter #(
   parameter int ANCHO = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inicio,
   input  logic [2:0]       op,
   input  logic [ANCHO-1:0] a,
   input  logic [ANCHO-1:0] b,
   output logic             ocupado,
   output logic             listo,
   output logic [ANCHO-1:0] Y,
   output logic             cero
);

   localparam int CW = $clog2(ANCHO);
   localparam int W2 = 2 * ANCHO;

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      CALC   = 2'd1,
      FIN    = 2'd2
   } estado_t;

   estado_t          state_reg, state_next;
   logic [CW-1:0]    count_reg;
   logic [2:0]       op_reg;
   // hi_reg: product high half / partial remainder
   // lo_reg: multiplier being shifted out / dividend shifting into quotient
   // opnd_reg: multiplicand magnitude / divisor magnitude
   logic [ANCHO-1:0] hi_reg, lo_reg, opnd_reg;
   logic             a_neg_reg, b_neg_reg, div0_reg;
   logic [ANCHO-1:0] y_reg;
   logic             cero_reg;

   logic             a_sgn, b_sgn, a_neg, b_neg;
   logic [ANCHO-1:0] a_mag, b_mag;
   logic             load, last_step;

   logic [ANCHO:0]   sum, r_sh;
   logic             ge;
   logic [ANCHO-1:0] hi_step, lo_step;
   logic [W2-1:0]    prod_mag, prod_sgn;
   logic [ANCHO-1:0] quo, rem, result;

   // Operand signedness: MULHU/DIVU/REMU unsigned, MULHSU has unsigned rs2
   assign a_sgn = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
   assign b_sgn = a_sgn && (op != 3'b010);
   assign a_neg = a_sgn && a[ANCHO-1];
   assign b_neg = b_sgn && b[ANCHO-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // A start is accepted whenever no iteration is running (idle or result cycle)
   assign load      = inicio && (state_reg != CALC);
   assign last_step = (count_reg == CW'(ANCHO - 1));

   // One unsigned iteration step of the selected algorithm
   always_comb begin
      sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
      r_sh = {hi_reg, lo_reg[ANCHO-1]};
      ge   = (r_sh >= {1'b0, opnd_reg});
      if (op_reg[2]) begin
         // the difference is always below the divisor, so it fits in ANCHO bits
         hi_step = ge ? (r_sh[ANCHO-1:0] - opnd_reg) : r_sh[ANCHO-1:0];
         lo_step = {lo_reg[ANCHO-2:0], ge};
      end else begin
         hi_step = sum[ANCHO:1];
         lo_step = {sum[0], lo_reg[ANCHO-1:1]};
      end
   end

   // Sign fix-up and result selection from the final step's values
   always_comb begin
      prod_mag = {hi_step, lo_step};
      prod_sgn = (a_neg_reg ^ b_neg_reg) ? -prod_mag : prod_mag;
      quo      = (a_neg_reg ^ b_neg_reg) ? -lo_step : lo_step;
      // remainder follows the dividend; REM by zero naturally yields a
      rem      = a_neg_reg ? -hi_step : hi_step;
      result   = '0;
      if (!op_reg[2]) begin
         result = (op_reg[1:0] == 2'b00) ? prod_sgn[ANCHO-1:0] : prod_sgn[W2-1:ANCHO];
      end else if (!op_reg[1]) begin
         // signed quotient magnitude would get negated, so force all ones
         result = div0_reg ? '1 : quo;
      end else begin
         result = rem;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         REPOSO:  if (inicio) state_next = CALC;
         CALC:    if (last_step) state_next = FIN;
         FIN:     state_next = inicio ? CALC : REPOSO;
         default: state_next = REPOSO;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= REPOSO;
      else       state_reg <= state_next;
   end

   // Operand capture, iteration and result write
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
         op_reg    <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         opnd_reg  <= '0;
         a_neg_reg <= 1'b0;
         b_neg_reg <= 1'b0;
         div0_reg  <= 1'b0;
         y_reg     <= '0;
         cero_reg  <= 1'b1;
      end else if (load) begin
         count_reg <= '0;
         op_reg    <= op;
         hi_reg    <= '0;
         lo_reg    <= op[2] ? a_mag : b_mag;
         opnd_reg  <= op[2] ? b_mag : a_mag;
         a_neg_reg <= a_neg;
         b_neg_reg <= b_neg;
         div0_reg  <= (b == '0);
      end else if (state_reg == CALC) begin
         count_reg <= count_reg + 1'b1;
         hi_reg    <= hi_step;
         lo_reg    <= lo_step;
         if (last_step) begin
            y_reg    <= result;
            cero_reg <= (result == '0);
         end
      end
   end

   assign ocupado = (state_reg == CALC);
   assign listo   = (state_reg == FIN);
   assign Y       = y_reg;
   assign cero    = cero_reg;

endmodule

// File: tb/tb_mul_div_iter.sv
// Self-checking bench for mul_div_iter at ANCHO=32 and ANCHO=8, using an
// integer-arithmetic reference model of the RV32M result rules.
module tb_mul_div_iter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inicio32, inicio8;
   logic [2:0]  op32, op8;
   logic [31:0] a32, b32, y32;
   logic [7:0]  a8, b8, y8;
   logic        ocupado32, listo32, cero32;
   logic        ocupado8, listo8, cero8;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mul_div_iter #(.ANCHO(32)) dut32 (
      .clk(clk), .reset(reset), .inicio(inicio32), .op(op32), .a(a32), .b(b32),
      .ocupado(ocupado32), .listo(listo32), .Y(y32), .cero(cero32)
   );

   mul_div_iter #(.ANCHO(8)) dut8 (
      .clk(clk), .reset(reset), .inicio(inicio8), .op(op8), .a(a8), .b(b8),
      .ocupado(ocupado8), .listo(listo8), .Y(y8), .cero(cero8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: RV32M rules evaluated with 64-bit integer arithmetic
   function automatic logic [31:0] ref_model(input int w, input logic [2:0] o,
                                              input logic [31:0] a_i, input logic [31:0] b_i);
      longint ua, ub, sa, sb, p, r, most_neg;
      longint unsigned pu;
      logic ovf;
      ua = longint'({32'd0, a_i});
      ub = longint'({32'd0, b_i});
      sa = a_i[w-1] ? ua - (longint'(1) << w) : ua;
      sb = b_i[w-1] ? ub - (longint'(1) << w) : ub;
      most_neg = -(longint'(1) << (w - 1));
      ovf = (sa == most_neg) && (sb == -1);
      r = 0;
      case (o)
         3'd0: r = sa * sb;
         3'd1: begin p = sa * sb; r = p >>> w; end
         3'd2: begin p = sa * ub; r = p >>> w; end
         3'd3: begin pu = ua * ub; r = longint'(pu >> w); end
         3'd4: r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
         3'd5: r = (ub == 0) ? -1 : ua / ub;
         3'd6: r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r & ((longint'(1) << w) - 1));
   endfunction

   task automatic drive(input int w, input logic st, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y);
      if (w == 8) begin
         inicio8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0];
      end else begin
         inicio32 = st; op32 = o; a32 = x; b32 = y;
      end
   endtask

   function automatic logic get_listo(input int w);
      return (w == 8) ? listo8 : listo32;
   endfunction

   function automatic logic get_ocup(input int w);
      return (w == 8) ? ocupado8 : ocupado32;
   endfunction

   function automatic logic get_cero(input int w);
      return (w == 8) ? cero8 : cero32;
   endfunction

   function automatic logic [31:0] get_y(input int w);
      return (w == 8) ? {24'd0, y8} : y32;
   endfunction

   // One full transaction: start, scramble inputs, wait for listo, check
   task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_y, input string tag);
      int lat;
      int busy;
      logic [31:0] got;
      @(negedge clk);
      drive(w, 1'b1, o, x, y);
      @(negedge clk);
      drive(w, 1'b0, 3'($urandom), $urandom, $urandom);
      lat  = 1;
      busy = 0;
      while (!get_listo(w) && lat < 4 * w) begin
         if (get_ocup(w)) busy++;
         @(negedge clk);
         lat++;
      end
      got = get_y(w);
      check({tag, "_lat"}, 32'(lat), 32'(w + 1));
      check({tag, "_busy"}, 32'(busy), 32'(w));
      check({tag, "_ocup_at_listo"}, {31'd0, get_ocup(w)}, 32'd0);
      check({tag, "_y"}, got, exp_y);
      check({tag, "_cero"}, {31'd0, get_cero(w)}, {31'd0, exp_y == 32'd0});
      $display("[%0t] %s w=%0d op=%0d a=%h b=%h y=%h exp=%h lat=%0d",
               $time, tag, w, o, x, y, got, exp_y, lat);
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, get_listo(w)}, 32'd0);
      check({tag, "_hold"}, get_y(w), exp_y);
   endtask

   // Hard stop in case something hangs
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt_l;
      int cnt_o;
      logic [2:0] o;
      logic [31:0] ra, rb, msk;
      int w;

      reset = 1'b1;
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(8, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ocup32", {31'd0, ocupado32}, 32'd0);
      check("rst_listo32", {31'd0, listo32}, 32'd0);
      check("rst_y32", y32, 32'd0);
      check("rst_cero32", {31'd0, cero32}, 32'd1);
      check("rst_y8", {24'd0, y8}, 32'd0);
      check("rst_cero8", {31'd0, cero8}, 32'd1);

      // Directed multiply / divide / special cases at ANCHO=32
      run_op(32, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
      run_op(32, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
      run_op(32, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
      run_op(32, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
      run_op(32, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div");
      run_op(32, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem");
      run_op(32, 3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, "divu");
      run_op(32, 3'b111, 32'hFFFFFFF9, 32'd2,        32'd1,        "remu");
      run_op(32, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0");
      run_op(32, 3'b110, 32'd5,        32'd0,        32'd5,        "rem_by0");
      run_op(32, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, "div_by0");
      run_op(32, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
      run_op(32, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf");

      // Handshake: busy window, ignored mid-run start, back-to-back start
      @(negedge clk);
      drive(32, 1'b1, 3'b000, 32'd3, 32'd5);
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (i == 1)  drive(32, 1'b0, 3'b000, 32'd3, 32'd5);
         if (i == 10) drive(32, 1'b1, 3'b101, 32'd100, 32'd7);
         if (i == 11) drive(32, 1'b0, 3'b101, 32'd100, 32'd7);
         check("hs_busy", {30'd0, ocupado32, listo32}, 32'd2);
      end
      @(negedge clk);
      check("hs_listo", {30'd0, ocupado32, listo32}, 32'd1);
      check("hs_y", y32, 32'd15);
      $display("[%0t] handshake w=32 op=0 a=3 b=5 y=%h exp=%h", $time, y32, 32'd15);
      drive(32, 1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(negedge clk);
      drive(32, 1'b0, 3'b000, 32'd0, 32'd0);
      check("b2b_started", {30'd0, ocupado32, listo32}, 32'd2);
      lat = 1;
      while (!listo32 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_lat", 32'(lat), 32'd33);
      check("b2b_y", y32, 32'hFFFFFFFE);
      $display("[%0t] back_to_back w=32 op=3 y=%h lat=%0d", $time, y32, lat);

      // Reset in cycle 25 of an operation aborts it
      @(negedge clk);
      drive(32, 1'b1, 3'b101, 32'd100, 32'd7);
      @(negedge clk);
      drive(32, 1'b0, 3'b000, 32'd0, 32'd0);
      repeat (24) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ocup", {31'd0, ocupado32}, 32'd0);
      check("abort_y", y32, 32'd0);
      check("abort_cero", {31'd0, cero32}, 32'd1);
      cnt_l = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (listo32) cnt_l++;
      end
      check("abort_no_listo", 32'(cnt_l), 32'd0);
      $display("[%0t] abort w=32 listo_pulses=%0d", $time, cnt_l);

      // Reset and start in the same cycle: the start is dropped
      @(negedge clk);
      reset = 1'b1;
      drive(32, 1'b1, 3'b000, 32'd3, 32'd5);
      @(negedge clk);
      reset = 1'b0;
      drive(32, 1'b0, 3'b000, 32'd0, 32'd0);
      cnt_o = 0;
      cnt_l = 0;
      for (int i = 0; i < 40; i++) begin
         if (ocupado32) cnt_o++;
         if (listo32) cnt_l++;
         @(negedge clk);
      end
      check("rst_start_ocup", 32'(cnt_o), 32'd0);
      check("rst_start_listo", 32'(cnt_l), 32'd0);
      $display("[%0t] reset_and_start w=32 busy_cycles=%0d listo_pulses=%0d", $time, cnt_o, cnt_l);

      // Narrow instance
      run_op(8, 3'b000, 32'h0F, 32'h11, 32'hFF, "mul8");

      // Randomised operations against the reference model, both widths
      for (int wi = 0; wi < 2; wi++) begin
         w   = (wi == 0) ? 32 : 8;
         msk = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
         for (int k = 0; k < 240; k++) begin
            o  = 3'(k % 8);
            ra = $urandom & msk;
            rb = $urandom & msk;
            case ($urandom_range(0, 9))
               0: rb = 32'd0;
               1: rb = msk;
               2: begin ra = 32'd1 << (w - 1); rb = msk; end
               3: rb = $urandom_range(1, 9);
               default: ;
            endcase
            run_op(w, o, ra, rb, ref_model(w, o, ra, rb), "rnd");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
